// File: rtl/dac_pkg.sv
// Shared definitions for the quad 12-bit DAC update scheduler.
// Frame word layout (24 bits): {cmd[3:0], addr[3:0], data[11:0], 4'b0000}.
package dac_pkg;

  localparam int unsigned NCH    = 4;
  localparam int unsigned DW     = 12;
  localparam int unsigned WORD_W = 24;

  // Field offsets within the frame word
  localparam int unsigned CMD_LSB  = 20;
  localparam int unsigned ADDR_LSB = 16;
  localparam int unsigned DATA_LSB = 4;

  // Command nibbles
  localparam logic [3:0] CMD_WRUPD = 4'b0011;
  localparam logic [3:0] CMD_PWRDN = 4'b0100;
  localparam logic [3:0] CMD_NOP   = 4'b1111;

  localparam logic [3:0] ADDR_ALL  = 4'b1111;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } sched_state_t;

  function automatic logic [WORD_W-1:0] mk_word(input logic [3:0]    cmd,
                                                input logic [3:0]    addr,
                                                input logic [DW-1:0] data);
    return {cmd, addr, data, 4'h0};
  endfunction

endpackage

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin picker.
// Ports:
//   req       - request vector, one bit per channel
//   ptr       - highest-priority channel; search runs upward with wrap 3->0
//   gnt_valid - at least one request present
//   gnt       - first requesting channel at or after ptr
module rr_arb4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       gnt_valid,
  output logic [1:0] gnt
);

  logic [1:0] idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt       = ptr;
    idx       = ptr;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt       = idx;
      end
    end
  end

endmodule

// File: rtl/dac_update_sched.sv
// Scheduler in front of the 24-bit SPI shift engine for a quad 12-bit DAC.
// Coalesces per-channel sample updates (latest wins), grants one pending
// channel per frame in round-robin order and presents the next frame word.
// After reset an all-channel init write is presented; idle/disabled frames
// carry NOP words.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   enable       - 1: schedule channel writes; 0: NOP frames only
//   ch_wr        - per-channel write strobe
//   ch_data      - per-channel sample, channel n at [12n+11:12n]
//   frame_ena    - engine has latched spi_word for transmission
//   spi_word     - word for the next frame
//   sent_valid   - pulse: a channel write frame was just latched
//   sent_ch      - channel of that frame
//   pending      - per-channel pending flags
//   overrun      - sticky: channel written while already pending
//   clr_overrun  - clears overrun (a simultaneous overrun event wins)
module dac_update_sched
  import dac_pkg::*;
#(
  parameter logic [DW-1:0] INIT_VAL = 12'h800
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [NCH-1:0]      ch_wr,
  input  logic [NCH*DW-1:0]   ch_data,
  input  logic                frame_ena,
  output logic [WORD_W-1:0]   spi_word,
  output logic                sent_valid,
  output logic [1:0]          sent_ch,
  output logic [NCH-1:0]      pending,
  output logic [NCH-1:0]      overrun,
  input  logic                clr_overrun
);

  sched_state_t      state_q, state_d;
  logic [WORD_W-1:0] spi_word_q, spi_word_d;
  logic [NCH-1:0]    pending_q, pending_d;
  logic [NCH-1:0]    overrun_q, overrun_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [DW-1:0]     hold_q [NCH];
  logic [DW-1:0]     hold_d [NCH];
  logic              sent_valid_q, sent_valid_d;
  logic [1:0]        sent_ch_q, sent_ch_d;
  // Describes the word currently on spi_word, reported once the engine latches it
  logic              cur_wr_q, cur_wr_d;
  logic [1:0]        cur_ch_q, cur_ch_d;

  logic [NCH-1:0]    req;
  logic              gnt_valid;
  logic [1:0]        gnt;
  logic              take;

  assign req = pending_q & {NCH{enable}};

  rr_arb4 u_arb (
    .req       (req),
    .ptr       (rr_ptr_q),
    .gnt_valid (gnt_valid),
    .gnt       (gnt)
  );

  assign take = frame_ena && gnt_valid;

  always_comb begin
    state_d      = state_q;
    spi_word_d   = spi_word_q;
    pending_d    = pending_q;
    overrun_d    = clr_overrun ? '0 : overrun_q;
    rr_ptr_d     = rr_ptr_q;
    hold_d       = hold_q;
    sent_valid_d = 1'b0;
    sent_ch_d    = sent_ch_q;
    cur_wr_d     = cur_wr_q;
    cur_ch_d     = cur_ch_q;

    if (frame_ena) begin
      state_d = ST_RUN;
      if (state_q == ST_RUN && cur_wr_q) begin
        sent_valid_d = 1'b1;
        sent_ch_d    = cur_ch_q;
      end
      if (gnt_valid) begin
        spi_word_d     = mk_word(CMD_WRUPD, {2'b00, gnt}, hold_q[gnt]);
        pending_d[gnt] = 1'b0;
        rr_ptr_d       = gnt + 2'd1;
        cur_wr_d       = 1'b1;
        cur_ch_d       = gnt;
      end else begin
        spi_word_d = mk_word(CMD_NOP, 4'h0, '0);
        cur_wr_d   = 1'b0;
      end
    end

    // Capture after the grant clear: a write landing on the granting cycle
    // re-arms pending with the new value, and the old value counts as consumed.
    for (int unsigned n = 0; n < NCH; n++) begin
      if (ch_wr[n]) begin
        hold_d[n]    = ch_data[n*DW +: DW];
        pending_d[n] = 1'b1;
        if (pending_q[n] && !(take && gnt == 2'(n)))
          overrun_d[n] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_INIT;
      spi_word_q   <= mk_word(CMD_WRUPD, ADDR_ALL, INIT_VAL);
      pending_q    <= '0;
      overrun_q    <= '0;
      rr_ptr_q     <= '0;
      sent_valid_q <= 1'b0;
      sent_ch_q    <= '0;
      cur_wr_q     <= 1'b0;
      cur_ch_q     <= '0;
      for (int unsigned n = 0; n < NCH; n++) hold_q[n] <= '0;
    end else begin
      state_q      <= state_d;
      spi_word_q   <= spi_word_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      rr_ptr_q     <= rr_ptr_d;
      sent_valid_q <= sent_valid_d;
      sent_ch_q    <= sent_ch_d;
      cur_wr_q     <= cur_wr_d;
      cur_ch_q     <= cur_ch_d;
      hold_q       <= hold_d;
    end
  end

  assign spi_word   = spi_word_q;
  assign sent_valid = sent_valid_q;
  assign sent_ch    = sent_ch_q;
  assign pending    = pending_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/dac_update_sched.md
Name: dac_update_sched

Overview:
- Scheduler that sits in front of the 24-bit SPI shift engine driving the quad 12-bit DAC (LTC2624-style command word).
- Accepts sample updates from four oscillator channels and coalesces them per channel (latest value wins).
- Grants one pending channel per SPI frame in round-robin order, and presents the next frame word to the engine.
- Sends an initial all-channel write after reset and NOP frames when idle or disabled.

Parameters:
- NCH, 4, number of DAC channels (fixed at 4; addr = channel index).
- DW, 12, DAC sample width.
- INIT_VAL, 12'h800, value written to all channels by the post-reset init frame.
- CMD_WRUPD, 4'b0011, command nibble "write and update channel".
- CMD_NOP, 4'b1111, command nibble "no operation".

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  1 = schedule channel writes; 0 = send NOP frames only (pending state retained)
- ch_wr  in  4  per-channel write strobe, one bit per channel
- ch_data  in  48  per-channel sample; channel n at bits [12n+11:12n]
- frame_ena  in  1  one-cycle pulse from SPI engine: current spi_word has been latched for transmission
- spi_word  out  24  word for next frame: {cmd[3:0], addr[3:0], data[11:0], 4'b0000}
- sent_valid  out  1  one-cycle pulse: a channel write frame was just latched by the engine
- sent_ch  out  2  channel of that write frame (valid with sent_valid)
- pending  out  4  per-channel pending flags
- overrun  out  4  sticky: channel n was written while already pending
- clr_overrun  in  1  clears all overrun bits

Behaviour:
- Reset values: state=INIT; spi_word={CMD_WRUPD,4'b1111,INIT_VAL,4'h0}; pending=0; overrun=0; sent_valid=0; sent_ch=0; rr_ptr=0; hold regs=0.
- Channel capture: ch_wr[n] loads hold[n] <= ch_data slice and sets pending[n] on the next edge.
  - If pending[n] is already 1, overrun[n] is also set.
  - clr_overrun clears overrun; a simultaneous overrun event wins (bit stays 1).
- FSM states:
  - INIT: spi_word holds the init word. On frame_ena, go to RUN, load the next word, and do not pulse sent_valid.
  - RUN: on each frame_ena, pulse sent_valid/sent_ch if the latched word was a channel write, then compute the next word.
- Next-word selection, registered, visible on spi_word 1 cycle after frame_ena:
  - If enable=1 and pending!=0: grant = first pending channel at or after rr_ptr, searching upward with wrap 3->0.
    - spi_word={CMD_WRUPD, {2'b00,grant}, hold[grant], 4'h0}.
    - Clear pending[grant]; rr_ptr <= grant+1 (mod 4).
  - Otherwise spi_word={CMD_NOP,4'h0,12'h000,4'h0}; rr_ptr is unchanged.
- Simultaneous events:
  - ch_wr[g] on the same cycle as the frame_ena that grants g: the word uses the old hold[g]. hold[g] takes the new value and pending[g] remains 1. No overrun is flagged (the old value was consumed).
  - ch_wr on a non-granted channel during frame_ena behaves normally.
- spi_word is stable between frame_ena pulses and never changes except on the edge after frame_ena or on reset.
- Reset mid-frame returns to INIT immediately. The engine may transmit a partially stale frame; this is acceptable.
- Minimum frame_ena spacing is 2 cycles (real spacing is 50); back-to-back pulses are not supported.
- Latency: a write to a non-pending channel is transmitted at most 4 frames after the next frame_ena.

Decomposition:
- Shared package dac_pkg: command nibbles (CMD_WRUPD, CMD_NOP, CMD_PWRDN), ADDR_ALL=4'b1111, NCH, DW, word-field offsets.
- Sub-module rr_arb4: combinational 4-way round-robin picker.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: gnt_valid, gnt[1:0].

Test Plan:
- Reset, then first frame_ena -> spi_word before pulse = 24'h3F8000; after pulse = 24'hF00000 (NOP); no sent_valid.
- In RUN, ch_wr=4'b0100 with ch2 data 12'hABC, then frame_ena -> next cycle spi_word=24'h32ABC0 and pending=0. The following frame_ena pulses sent_valid with sent_ch=2.
- All four channels written (data n*0x111) in one cycle, then 4 frame_ena pulses -> words carry addresses 0,1,2,3 in order; the 5th word is NOP. Repeat with rr_ptr=2 -> order 2,3,0,1.
- ch1 written 12'h100 then 12'h200 before any frame -> overrun[1]=1 and the transmitted data is 12'h200. clr_overrun -> overrun=0.
- ch0 pending, ch_wr[0]=1 with 12'h555 on the granting frame_ena cycle -> word holds the old value, pending[0] stays 1, and the next frame sends 12'h555.
- enable=0 with ch3 pending -> NOP words only, pending[3] kept. enable=1 -> the next frame sends ch3. Reset mid-sequence -> init word reappears and pending=0.
